// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback commit stage for the integer register file.
// Merges unbuffered LSU results (priority) with buffered ALU results into one
// registered write per cycle. It also keeps the pending-write scoreboard that
// decode reads. Define WB_COMMIT_PERF_EN to add three wrapping perf counters.
module wb_commit_unit #(
    parameter int XLEN      = 64,
    parameter int ALU_DEPTH = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_wd,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_wd,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wd,
    output logic [31:0]     busy
`ifdef WB_COMMIT_PERF_EN
    ,
    output logic [31:0]     perf_commits,
    output logic [31:0]     perf_alu_stall,
    output logic [31:0]     perf_lsu_stall
`endif
);

    localparam int          AW      = $clog2(ALU_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [4:0]      fifo_rd [ALU_DEPTH];
    logic [XLEN-1:0] fifo_wd [ALU_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_wd;
    logic [31:0]     busy_next;

    // The extra wrap bit on each pointer tells a full FIFO apart from an empty one.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign alu_ready = !full;
    assign push      = alu_valid && !full;

    // FIFO storage: written on push, read through the head pointer.
    // NOTE: the data array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr[AW-1:0]] <= alu_rd;
            fifo_wd[wr_ptr[AW-1:0]] <= alu_wd;
        end
    end

    // FIFO pointers. A push and a pop may happen in the same cycle.
    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Arbitration. LSU wins unless the FIFO is full, and then the FIFO head drains first.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_wd    = '0;
        lsu_ready = 1'b0;
        pop       = 1'b0;
        if (lsu_valid && !full) begin
            sel_valid = 1'b1;
            lsu_ready = 1'b1;
            sel_rd    = lsu_rd;
            sel_wd    = lsu_wd;
        end else if (!empty) begin
            sel_valid = 1'b1;
            pop       = 1'b1;
            sel_rd    = fifo_rd[rd_ptr[AW-1:0]];
            sel_wd    = fifo_wd[rd_ptr[AW-1:0]];
        end
    end

    // Register-file write port. A write to x0 is consumed but not enabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we <= 1'b0;
            rd <= '0;
            wd <= '0;
        end else begin
            we <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                rd <= sel_rd;
                wd <= sel_wd;
            end
        end
    end

    // Scoreboard next state. The clear happens on the edge that commits rd.
    // A set on the same edge wins, and x0 is never marked busy.
    always_comb begin
        busy_next = busy;
        if (we) busy_next[rd] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0)) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) busy <= '0;
        else         busy <= busy_next;
    end

`ifdef WB_COMMIT_PERF_EN
    // Wrapping perf counters for commits and for stalls on each input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_commits   <= '0;
            perf_alu_stall <= '0;
            perf_lsu_stall <= '0;
        end else begin
            if (we)                      perf_commits   <= perf_commits + 32'd1;
            if (alu_valid && !alu_ready) perf_alu_stall <= perf_alu_stall + 32'd1;
            if (lsu_valid && !lsu_ready) perf_lsu_stall <= perf_lsu_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: self-checking bench for wb_commit_unit (default build).
// A queue-based behavioural model tracks the expected outputs. One negedge
// process compares every output against it. Directed sections add literal
// expectations, and a randomized phase exercises mixed traffic.
module tb_wb_commit_unit;

    localparam int XLEN      = 64;
    localparam int ALU_DEPTH = 4;

    logic            clk         = 1'b0;
    logic            resetn      = 1'b0;
    logic            alu_valid   = 1'b0;
    logic [4:0]      alu_rd      = '0;
    logic [XLEN-1:0] alu_wd      = '0;
    logic            lsu_valid   = 1'b0;
    logic [4:0]      lsu_rd      = '0;
    logic [XLEN-1:0] lsu_wd      = '0;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_rd    = '0;
    logic            alu_ready;
    logic            lsu_ready;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
    logic [31:0]     busy;

    int checks   = 0;
    int failures = 0;

    wb_commit_unit #(.XLEN(XLEN), .ALU_DEPTH(ALU_DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_wd     (alu_wd),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_wd     (lsu_wd),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .we         (we),
        .rd         (rd),
        .wd         (wd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a queue of pending ALU results plus the expected write-port and scoreboard state.
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } ent_t;

    ent_t            m_q[$];
    logic            m_we   = 1'b0;
    logic [4:0]      m_rd   = '0;
    logic [XLEN-1:0] m_wd   = '0;
    logic [31:0]     m_busy = '0;
    bit              m_full;
    bit              m_sel;
    ent_t            m_s;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_we   = 1'b0;
            m_rd   = '0;
            m_wd   = '0;
            m_busy = '0;
        end else begin
            m_full = (m_q.size() == ALU_DEPTH);
            m_sel  = 1'b0;
            m_s    = '{5'd0, '0};
            if (lsu_valid && !m_full) begin
                m_sel = 1'b1;
                m_s   = '{lsu_rd, lsu_wd};
            end else if (m_q.size() != 0) begin
                m_sel = 1'b1;
                m_s   = m_q.pop_front();
            end
            if (m_we) m_busy[m_rd] = 1'b0;
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            m_we = m_sel && (m_s.rd != 5'd0);
            if (m_sel) begin
                m_rd = m_s.rd;
                m_wd = m_s.wd;
            end
            if (alu_valid && !m_full) m_q.push_back('{alu_rd, alu_wd});
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        check("alu_ready", {63'd0, alu_ready}, {63'd0, m_q.size() != ALU_DEPTH});
        check("lsu_ready", {63'd0, lsu_ready}, {63'd0, lsu_valid && (m_q.size() != ALU_DEPTH)});
        check("we", {63'd0, we}, {63'd0, m_we});
        check("rd", {59'd0, rd}, {59'd0, m_rd});
        check("wd", wd, m_wd);
        check("busy", {32'd0, busy}, {32'd0, m_busy});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int         pushed;
    int         cyc;
    bit         stall_seen;
    int         lsu_commits;
    logic [4:0] seq_rd[$];
    logic [63:0] seq_wd[$];
    bit         a_stall;
    bit         l_stall;

    initial begin
        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            alu_valid   = 1'($urandom);
            alu_rd      = 5'($urandom);
            alu_wd      = {$urandom, $urandom};
            lsu_valid   = 1'($urandom);
            lsu_rd      = 5'($urandom);
            lsu_wd      = {$urandom, $urandom};
            issue_valid = 1'($urandom);
            issue_rd    = 5'($urandom);
            tick();
        end
        check("reset_we", {63'd0, we}, 64'd0);
        check("reset_busy", {32'd0, busy}, 64'd0);
        check("reset_alu_ready", {63'd0, alu_ready}, 64'd1);
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_after_reset_we", {63'd0, we}, 64'd0);
        end

        // Single LSU result.
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_wd = 64'hDEAD;
        #1;
        check("lsu_single_ready", {63'd0, lsu_ready}, 64'd1);
        tick();
        lsu_valid = 1'b0;
        check("lsu_single_we", {63'd0, we}, 64'd1);
        check("lsu_single_rd", {59'd0, rd}, 64'd5);
        check("lsu_single_wd", wd, 64'hDEAD);

        // ALU burst r1..r6 against a steady LSU stream to r9.
        pushed = 0; cyc = 0; stall_seen = 1'b0; lsu_commits = 0;
        while ((pushed < 6 || cyc < 12) && cyc < 40) begin
            alu_valid = (pushed < 6);
            alu_rd    = 5'(pushed + 1);
            alu_wd    = 64'(32'h100 + pushed);
            lsu_valid = (pushed < 6);
            lsu_rd    = 5'd9;
            lsu_wd    = 64'h900;
            #1;
            if (pushed == 4 && !stall_seen) begin
                stall_seen = 1'b1;
                check("burst_alu_ready_full", {63'd0, alu_ready}, 64'd0);
                check("burst_lsu_ready_full", {63'd0, lsu_ready}, 64'd0);
            end
            if (alu_valid && alu_ready) pushed++;
            tick();
            cyc++;
            if (we) begin
                if (rd == 5'd9) lsu_commits++;
                else begin
                    seq_rd.push_back(rd);
                    seq_wd.push_back(wd);
                end
            end
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check("burst_all_pushed", 64'(pushed), 64'd6);
        check("burst_stall_seen", {63'd0, stall_seen}, 64'd1);
        check("burst_alu_commits", 64'(seq_rd.size()), 64'd6);
        check("burst_lsu_commits", 64'(lsu_commits), 64'd6);
        for (int i = 0; i < seq_rd.size() && i < 6; i++) begin
            check($sformatf("burst_order_rd%0d", i), {59'd0, seq_rd[i]}, 64'(i + 1));
            check($sformatf("burst_order_wd%0d", i), seq_wd[i], 64'(32'h100 + i));
        end

        // Zero register: consumed without a write, never marked busy.
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 64'h55;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check("zero_lsu_ready", {63'd0, lsu_ready}, 64'd1);
        tick();
        lsu_valid = 1'b0; issue_valid = 1'b0;
        check("zero_we", {63'd0, we}, 64'd0);
        check("zero_rd_updates", {59'd0, rd}, 64'd0);
        check("zero_wd_updates", wd, 64'h55);
        check("zero_busy0", {63'd0, busy[0]}, 64'd0);

        // Scoreboard set, hold, clear on the commit edge, and set-wins-over-clear.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("sb_set", {63'd0, busy[7]}, 64'd1);
        tick();
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 64'h77;
        tick();
        lsu_valid = 1'b0;
        check("sb_commit_we", {63'd0, we}, 64'd1);
        check("sb_busy_during_commit", {63'd0, busy[7]}, 64'd1);
        tick();
        check("sb_cleared", {63'd0, busy[7]}, 64'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 64'h78;
        tick();
        lsu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        check("sb_same_edge_we", {63'd0, we}, 64'd1);
        tick();
        issue_valid = 1'b0;
        check("sb_set_wins", {63'd0, busy[7]}, 64'd1);
        tick();
        check("sb_set_holds", {63'd0, busy[7]}, 64'd1);

        // Randomized traffic. Stalled requests hold their inputs.
        a_stall = 1'b0; l_stall = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (!a_stall) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd    = 5'($urandom);
                alu_wd    = {$urandom, $urandom};
            end
            if (!l_stall) begin
                lsu_valid = ($urandom_range(0, 99) < 40);
                lsu_rd    = 5'($urandom);
                lsu_wd    = {$urandom, $urandom};
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = 5'($urandom);
            #1;
            a_stall = alu_valid && !alu_ready;
            l_stall = lsu_valid && !lsu_ready;
            tick();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Reset mid-burst with three ALU entries queued.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(11 + i); alu_wd = 64'(32'hB00 + i);
            lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_wd = 64'h2000;
            issue_valid = (i == 0); issue_rd = 5'd15;
            tick();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        check("pre_reset_we", {63'd0, we}, 64'd1);
        check("pre_reset_rd", {59'd0, rd}, 64'd20);
        check("pre_reset_busy15", {63'd0, busy[15]}, 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_we", {63'd0, we}, 64'd0);
        check("async_reset_rd", {59'd0, rd}, 64'd0);
        check("async_reset_busy", {32'd0, busy}, 64'd0);
        check("async_reset_alu_ready", {63'd0, alu_ready}, 64'd1);
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_stale_commit_we", {63'd0, we}, 64'd0);
        end
        check("post_reset_alu_ready", {63'd0, alu_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
